axil_cmd_master: RTL

AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

---
 rtl/axil_cmd_master.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: turns single commands into AXI4-Lite read/write transactions, one outstanding,
// with a per-phase cycle timeout that aborts the transaction and reports SLVERR.
module axil_cmd_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                    aclk_i,
   input  logic                    arst_i,
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic                    cmd_write_i,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
   output logic [1:0]              rsp_resp_o,
   output logic                    rsp_timeout_o,
   output logic [ADDR_WIDTH-1:0]   m_axil_awaddr_o,
   output logic [2:0]              m_axil_awprot_o,
   output logic                    m_axil_awvalid_o,
   input  logic                    m_axil_awready_i,
   output logic [DATA_WIDTH-1:0]   m_axil_wdata_o,
   output logic [DATA_WIDTH/8-1:0] m_axil_wstrb_o,
   output logic                    m_axil_wvalid_o,
   input  logic                    m_axil_wready_i,
   input  logic [1:0]              m_axil_bresp_i,
   input  logic                    m_axil_bvalid_i,
   output logic                    m_axil_bready_o,
   output logic [ADDR_WIDTH-1:0]   m_axil_araddr_o,
   output logic [2:0]              m_axil_arprot_o,
   output logic                    m_axil_arvalid_o,
   input  logic                    m_axil_arready_i,
   input  logic [DATA_WIDTH-1:0]   m_axil_rdata_i,
   input  logic [1:0]              m_axil_rresp_i,
   input  logic                    m_axil_rvalid_i,
   output logic                    m_axil_rready_o
);
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;
   state_t                    state_q, state_d;
   logic [15:0]               cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
   logic                      aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
   logic [1:0]                resp_q, resp_d;
   logic                      timeout_q, timeout_d;
   logic                      aw_hs, w_hs, expired, abort;

   assign cmd_ready_o      = (state_q == IDLE) && !arst_i;
   assign rsp_valid_o      = state_q == DONE;
   assign rsp_rdata_o      = rdata_q;
   assign rsp_resp_o       = resp_q;
   assign rsp_timeout_o    = timeout_q;
   assign m_axil_awaddr_o  = addr_q;
   assign m_axil_awprot_o  = 3'b000;
   assign m_axil_awvalid_o = (state_q == WR_REQ) && !aw_done_q;
   assign m_axil_wdata_o   = wdata_q;
   assign m_axil_wstrb_o   = wstrb_q;
   assign m_axil_wvalid_o  = (state_q == WR_REQ) && !w_done_q;
   assign m_axil_bready_o  = state_q == WR_RESP;
   assign m_axil_araddr_o  = addr_q;
   assign m_axil_arprot_o  = 3'b000;
   assign m_axil_arvalid_o = state_q == RD_REQ;
   assign m_axil_rready_o  = state_q == RD_RESP;
   assign aw_hs            = m_axil_awvalid_o && m_axil_awready_i;
   assign w_hs             = m_axil_wvalid_o && m_axil_wready_i;
   assign expired          = cnt_q == CNT_LAST;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      aw_done_d = aw_done_q || aw_hs;
      w_done_d  = w_done_q || w_hs;
      rdata_d   = rdata_q;
      resp_d    = resp_q;
      timeout_d = timeout_q;
      abort     = 1'b0;
      case (state_q)
         IDLE: if (cmd_valid_i) begin
            state_d   = cmd_write_i ? WR_REQ : RD_REQ;
            addr_d    = cmd_addr_i;
            wdata_d   = cmd_wdata_i;
            wstrb_d   = cmd_wstrb_i;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            rdata_d   = '0;
            resp_d    = 2'b00;
            timeout_d = 1'b0;
         end
         WR_REQ: if (aw_done_d && w_done_d) state_d = WR_RESP; else abort = expired;
         WR_RESP: if (m_axil_bvalid_i) begin
            resp_d  = m_axil_bresp_i;
            state_d = DONE;
         end else abort = expired;
         RD_REQ: if (m_axil_arready_i) state_d = RD_RESP; else abort = expired;
         RD_RESP: if (m_axil_rvalid_i) begin
            rdata_d = m_axil_rdata_i;
            resp_d  = m_axil_rresp_i;
            state_d = DONE;
         end else abort = expired;
         DONE: if (rsp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // a handshake in the expiring cycle has already moved the state, so it beats the timeout
      if (abort) begin
         state_d   = DONE;
         rdata_d   = '0;
         resp_d    = 2'b10;
         timeout_d = 1'b1;
      end
      cnt_d = (state_d != state_q || state_q == IDLE || state_q == DONE) ? 16'd0 : cnt_q + 16'd1;
   end

   always_ff @(posedge aclk_i) begin
      if (arst_i) begin
         state_q   <= IDLE;
         cnt_q     <= 16'd0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rdata_q   <= '0;
         resp_q    <= 2'b00;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
         timeout_q <= timeout_d;
      end
   end
endmodule
